// File: rtl/demo_all_bus_arbiter.sv
// Two-master classic Wishbone arbiter in front of the demo_all register map.
// Round-robin grant, local rejection of bad addresses, and a slave-wait timeout.
module demo_all_bus_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAP_SIZE   = 8448,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [31:0]           m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [31:0]           m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [31:0]           m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [31:0]           m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic [31:0]           s_dat_i,
  output logic                  grant_o,
  output logic                  timeout_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] MAP_LIMIT = (ADDR_WIDTH + 1)'(MAP_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  lastGrant_q, lastGrant_d;
  logic                  sCyc_q, sCyc_d;
  logic                  sWe_q, sWe_d;
  logic [ADDR_WIDTH-1:0] sAdr_q, sAdr_d;
  logic [3:0]            sSel_q, sSel_d;
  logic [31:0]           sDat_q, sDat_d;
  logic [CW-1:0]         waitCnt_q, waitCnt_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [31:0]           m0Rdata_q, m0Rdata_d;
  logic [31:0]           m1Rdata_q, m1Rdata_d;
  logic                  timeout_q, timeout_d;

  logic [1:0]            req;
  logic                  pick;
  logic                  pickWe;
  logic [ADDR_WIDTH-1:0] pickAdr;
  logic [3:0]            pickSel;
  logic [31:0]           pickDat;
  logic                  pickIllegal;
  logic                  grantedCyc;
  logic                  respAck;
  logic                  respErr;
  logic [31:0]           respData;

  // On a tie the master that was not served last wins, so neither can starve.
  assign req         = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign pick        = (req == 2'b11) ? ~lastGrant_q : req[1];
  assign pickWe      = pick ? m1_we_i  : m0_we_i;
  assign pickAdr     = pick ? m1_adr_i : m0_adr_i;
  assign pickSel     = pick ? m1_sel_i : m0_sel_i;
  assign pickDat     = pick ? m1_dat_i : m0_dat_i;
  assign pickIllegal = ({1'b0, pickAdr} >= MAP_LIMIT) || (pickAdr[1:0] != 2'b00);
  assign grantedCyc  = grant_q ? m1_cyc_i : m0_cyc_i;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    sCyc_d      = sCyc_q;
    sWe_d       = sWe_q;
    sAdr_d      = sAdr_q;
    sSel_d      = sSel_q;
    sDat_d      = sDat_q;
    waitCnt_d   = waitCnt_q;
    timeout_d   = 1'b0;
    m0Rdata_d   = m0Rdata_q;
    m1Rdata_d   = m1Rdata_q;
    respAck     = 1'b0;
    respErr     = 1'b0;
    respData    = '0;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d = pick;
          if (pickIllegal) begin
            respErr = 1'b1;
            state_d = RESP;
          end else begin
            sCyc_d    = 1'b1;
            sWe_d     = pickWe;
            sAdr_d    = pickAdr;
            sSel_d    = pickSel;
            sDat_d    = pickDat;
            waitCnt_d = '0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        waitCnt_d = waitCnt_q + CW'(1);
        // A master walking away mid-access gets no response but still counts as served.
        if (!grantedCyc) begin
          sCyc_d      = 1'b0;
          lastGrant_d = grant_q;
          state_d     = IDLE;
        end else if (s_err_i) begin
          sCyc_d  = 1'b0;
          respErr = 1'b1;
          state_d = RESP;
        end else if (s_ack_i) begin
          sCyc_d   = 1'b0;
          respAck  = 1'b1;
          respData = s_dat_i;
          state_d  = RESP;
        end else if (waitCnt_q == CNT_LAST) begin
          sCyc_d    = 1'b0;
          respErr   = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        lastGrant_d = grant_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (respAck || respErr) begin
      if (grant_d) m1Rdata_d = respData;
      else         m0Rdata_d = respData;
    end
    ack_d = respAck ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
    err_d = respErr ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      sCyc_q      <= 1'b0;
      sWe_q       <= 1'b0;
      sAdr_q      <= '0;
      sSel_q      <= '0;
      sDat_q      <= '0;
      waitCnt_q   <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      m0Rdata_q   <= '0;
      m1Rdata_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      sCyc_q      <= sCyc_d;
      sWe_q       <= sWe_d;
      sAdr_q      <= sAdr_d;
      sSel_q      <= sSel_d;
      sDat_q      <= sDat_d;
      waitCnt_q   <= waitCnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      m0Rdata_q   <= m0Rdata_d;
      m1Rdata_q   <= m1Rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign m0_ack_o  = ack_q[0];
  assign m0_err_o  = err_q[0];
  assign m0_dat_o  = m0Rdata_q;
  assign m1_ack_o  = ack_q[1];
  assign m1_err_o  = err_q[1];
  assign m1_dat_o  = m1Rdata_q;
  assign s_cyc_o   = sCyc_q;
  assign s_stb_o   = sCyc_q;
  assign s_we_o    = sWe_q;
  assign s_adr_o   = sAdr_q;
  assign s_sel_o   = sSel_q;
  assign s_dat_o   = sDat_q;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_demo_all_bus_arbiter.sv
// Self-checking bench for demo_all_bus_arbiter: directed scenarios plus a randomized
// run, all judged against a transfer-level model of the arbiter's rules.
module tb_demo_all_bus_arbiter;

  localparam int AW       = 14;
  localparam int MAP_SIZE = 8448;
  localparam int TIMEOUT  = 256;

  logic clk_i = 1'b0;
  logic rst_i;
  logic m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [3:0] m0_sel_i;
  logic [31:0] m0_dat_i;
  logic m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [3:0] m1_sel_i;
  logic [31:0] m1_dat_i;
  logic m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [3:0] s_sel_o;
  logic [31:0] s_dat_o;
  logic s_ack_i, s_err_i;
  logic [31:0] s_dat_i;
  logic grant_o, timeout_o;

  int nChecks = 0;
  int nFail = 0;
  int modelLast = 1;

  // Slave behaviour: 0 = ack, 1 = err, 2 = silent, 3 = ack and err together.
  int slaveWait = 0;
  int slaveMode = 0;
  logic ovrEn = 1'b0;
  logic [31:0] ovrData = 32'h0;
  int slvCnt = 0;
  int slvHits = 0;
  logic [AW-1:0] slvAdr = '0;
  logic slvWe = 1'b0;
  logic [3:0] slvSel = '0;
  logic [31:0] slvDat = '0;

  logic [122:0] allOut;
  assign allOut = {m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
                   s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, grant_o, timeout_o};

  typedef struct {
    int cycles;
    logic ack;
    logic err;
    logic [31:0] rdat;
    logic sawSlave;
    logic tmo;
    int tmoCount;
    logic otherResp;
    logic grant;
    int stbCount;
  } xfer_t;

  demo_all_bus_arbiter #(.ADDR_WIDTH(AW), .MAP_SIZE(MAP_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_dat_i(s_dat_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural slave: responds once its strobe has been up for slaveWait extra cycles.
  assign s_ack_i = s_stb_o && (slvCnt == slaveWait) && (slaveMode == 0 || slaveMode == 3);
  assign s_err_i = s_stb_o && (slvCnt == slaveWait) && (slaveMode == 1 || slaveMode == 3);
  assign s_dat_i = ovrEn ? ovrData : (32'hC0DE_0000 | 32'(s_adr_o));

  always @(posedge clk_i) begin
    if (s_stb_o && (s_ack_i || s_err_i)) begin
      slvHits <= slvHits + 1;
      slvAdr  <= s_adr_o;
      slvWe   <= s_we_o;
      slvSel  <= s_sel_o;
      slvDat  <= s_dat_o;
    end
    if (!s_stb_o || s_ack_i || s_err_i) slvCnt <= 0;
    else slvCnt <= slvCnt + 1;
  end

  function automatic logic [31:0] expData(input logic [AW-1:0] a);
    return ovrEn ? ovrData : (32'hC0DE_0000 | 32'(a));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic driveReq(input int m, input logic on, input logic we, input logic [AW-1:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = on; m0_stb_i = on; m0_we_i = we; m0_adr_i = adr; m0_sel_i = sel; m0_dat_i = dat;
    end else begin
      m1_cyc_i = on; m1_stb_i = on; m1_we_i = we; m1_adr_i = adr; m1_sel_i = sel; m1_dat_i = dat;
    end
  endtask

  // Runs one transfer as master m, observing until its response (bounded) then releasing.
  task automatic runXfer(input int m, input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat, output xfer_t r);
    logic ack, err;
    r.cycles = 0; r.ack = 1'b0; r.err = 1'b0; r.rdat = '0; r.sawSlave = 1'b0; r.tmo = 1'b0;
    r.tmoCount = 0; r.otherResp = 1'b0; r.grant = 1'b0; r.stbCount = 0;
    driveReq(m, 1'b1, we, adr, sel, wdat);
    while (!(r.ack || r.err) && r.cycles < 400) begin
      @(negedge clk_i);
      r.cycles++;
      ack = (m == 0) ? m0_ack_o : m1_ack_o;
      err = (m == 0) ? m0_err_o : m1_err_o;
      if (s_cyc_o) r.sawSlave = 1'b1;
      if (s_stb_o) r.stbCount++;
      if (timeout_o) r.tmoCount++;
      if ((m == 0) ? (m1_ack_o | m1_err_o) : (m0_ack_o | m0_err_o)) r.otherResp = 1'b1;
      if (ack || err) begin
        r.ack = ack; r.err = err; r.tmo = timeout_o; r.grant = grant_o;
        r.rdat = (m == 0) ? m0_dat_o : m1_dat_o;
      end
    end
    driveReq(m, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle(3);
    nChecks++;
    if (allOut !== '0) begin nFail++; $display("[TB] FAIL reset_outputs: got %h expected 0", allOut); end
    rst_i = 1'b0;
    idle(2);
    nChecks++;
    if (allOut !== '0) begin nFail++; $display("[TB] FAIL reset_quiet: got %h expected 0", allOut); end
    modelLast = 1;
  endtask

  task automatic test_single_read();
    xfer_t r;
    slaveMode = 0; slaveWait = 1; ovrEn = 1'b1; ovrData = 32'h123;
    runXfer(0, 1'b0, 14'h4, 4'hF, 32'h0, r);
    nChecks++;
    if ({r.ack, r.err} !== 2'b10) begin nFail++; $display("[TB] FAIL single_resp: got ack/err %b%b expected 10", r.ack, r.err); end
    nChecks++;
    if (r.cycles !== 3) begin nFail++; $display("[TB] FAIL single_latency: got %0d expected 3", r.cycles); end
    nChecks++;
    if (r.stbCount !== 2) begin nFail++; $display("[TB] FAIL single_stb_cycles: got %0d expected 2", r.stbCount); end
    nChecks++;
    if (r.rdat !== 32'h123) begin nFail++; $display("[TB] FAIL single_data: got %h expected 00000123", r.rdat); end
    nChecks++;
    if ({r.otherResp, m1_dat_o} !== 33'h0) begin nFail++; $display("[TB] FAIL single_m1_quiet: got %b/%h expected 0/0", r.otherResp, m1_dat_o); end
    nChecks++;
    if ({slvAdr, slvWe} !== {14'h4, 1'b0}) begin nFail++; $display("[TB] FAIL single_slave_req: got %h/%b expected 0004/0", slvAdr, slvWe); end
    idle(1);
    nChecks++;
    if ({m0_ack_o, m0_dat_o} !== {1'b0, 32'h123}) begin nFail++; $display("[TB] FAIL single_ack_once: got %b/%h expected 0/00000123", m0_ack_o, m0_dat_o); end
    ovrEn = 1'b0;
    modelLast = 0;
  endtask

  task automatic test_illegal();
    xfer_t r;
    logic [AW-1:0] adrs [2];
    int hits;
    adrs[0] = 14'h2100;
    adrs[1] = 14'h2082;
    slaveMode = 0; slaveWait = 0;
    for (int i = 0; i < 2; i++) begin
      hits = slvHits;
      runXfer(1, 1'b1, adrs[i], 4'hF, 32'hDEAD_BEEF, r);
      nChecks++;
      if ({r.ack, r.err, r.rdat} !== {2'b01, 32'h0}) begin nFail++; $display("[TB] FAIL illegal_resp_%0d: got %b%b/%h expected 01/0", i, r.ack, r.err, r.rdat); end
      nChecks++;
      if (r.cycles !== 1) begin nFail++; $display("[TB] FAIL illegal_latency_%0d: got %0d expected 1", i, r.cycles); end
      nChecks++;
      if ({r.sawSlave, slvHits - hits} !== {1'b0, 32'd0}) begin nFail++; $display("[TB] FAIL illegal_slave_untouched_%0d: got cyc=%b hits=%0d expected 0/0", i, r.sawSlave, slvHits - hits); end
      nChecks++;
      if (m0_dat_o !== 32'h123) begin nFail++; $display("[TB] FAIL illegal_m0_held_%0d: got %h expected 00000123", i, m0_dat_o); end
      modelLast = 1;
      idle(1);
    end
  endtask

  task automatic test_contention();
    xfer_t r0, r1;
    logic [AW-1:0] a0, a1;
    int wt, winner, loser, c0, c1;
    for (int k = 0; k < 4; k++) begin
      wt = $urandom_range(0, 2);
      slaveMode = 0; slaveWait = wt;
      a0 = 14'($urandom_range(0, MAP_SIZE / 4 - 1) * 4);
      a1 = 14'($urandom_range(0, MAP_SIZE / 4 - 1) * 4);
      fork
        runXfer(0, 1'b0, a0, 4'hF, 32'h0, r0);
        runXfer(1, 1'b0, a1, 4'hF, 32'h0, r1);
      join
      winner = 1 - modelLast;
      loser = modelLast;
      c0 = (winner == 0) ? 2 + wt : 5 + 2 * wt;
      c1 = (winner == 1) ? 2 + wt : 5 + 2 * wt;
      nChecks++;
      if (r0.cycles !== c0 || r1.cycles !== c1) begin nFail++; $display("[TB] FAIL contention_order_%0d: got m0=%0d m1=%0d cycles expected m0=%0d m1=%0d", k, r0.cycles, r1.cycles, c0, c1); end
      nChecks++;
      if ({r0.ack, r0.err, r1.ack, r1.err} !== 4'b1010) begin nFail++; $display("[TB] FAIL contention_resp_%0d: got %b%b%b%b expected 1010", k, r0.ack, r0.err, r1.ack, r1.err); end
      nChecks++;
      if ({r0.rdat, r1.rdat} !== {expData(a0), expData(a1)}) begin nFail++; $display("[TB] FAIL contention_data_%0d: got %h/%h expected %h/%h", k, r0.rdat, r1.rdat, expData(a0), expData(a1)); end
      nChecks++;
      if ({r0.grant, r1.grant} !== 2'b01) begin nFail++; $display("[TB] FAIL contention_grant_%0d: got %b%b expected 01", k, r0.grant, r1.grant); end
      modelLast = loser;
      idle(1);
      nChecks++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin nFail++; $display("[TB] FAIL contention_ack_once_%0d: got %b%b%b%b expected 0000", k, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o); end
    end
  endtask

  task automatic test_timeout();
    xfer_t r;
    slaveMode = 2; slaveWait = 0;
    runXfer(0, 1'b0, 14'h20, 4'hF, 32'h0, r);
    nChecks++;
    if ({r.ack, r.err, r.tmo, r.rdat} !== {3'b011, 32'h0}) begin nFail++; $display("[TB] FAIL timeout_resp: got ack=%b err=%b tmo=%b dat=%h expected 0/1/1/0", r.ack, r.err, r.tmo, r.rdat); end
    nChecks++;
    if (r.cycles !== TIMEOUT + 1) begin nFail++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", r.cycles, TIMEOUT + 1); end
    nChecks++;
    if (r.tmoCount !== 1) begin nFail++; $display("[TB] FAIL timeout_pulse_count: got %0d expected 1", r.tmoCount); end
    modelLast = 0;
    idle(1);
    nChecks++;
    if ({s_cyc_o, timeout_o, m0_err_o} !== 3'b000) begin nFail++; $display("[TB] FAIL timeout_after: got cyc/tmo/err %b%b%b expected 000", s_cyc_o, timeout_o, m0_err_o); end
    slaveMode = 0;
    runXfer(0, 1'b0, 14'h24, 4'hF, 32'h0, r);
    nChecks++;
    if ({r.ack, r.err, r.rdat, r.cycles} !== {2'b10, expData(14'h24), 32'd2}) begin nFail++; $display("[TB] FAIL timeout_recover: got %b%b/%h/%0d expected 10/%h/2", r.ack, r.err, r.rdat, r.cycles, expData(14'h24)); end
    idle(1);
  endtask

  task automatic test_abort();
    slaveMode = 2; slaveWait = 0;
    driveReq(1, 1'b1, 1'b0, 14'h100, 4'hF, 32'h0);
    idle(1);
    nChecks++;
    if ({s_cyc_o, grant_o, s_adr_o} !== {2'b11, 14'h100}) begin nFail++; $display("[TB] FAIL abort_granted: got %b%b/%h expected 11/0100", s_cyc_o, grant_o, s_adr_o); end
    driveReq(0, 1'b1, 1'b0, 14'h40, 4'hF, 32'h0);
    idle(2);
    m1_cyc_i = 1'b0;
    idle(1);
    nChecks++;
    if ({s_cyc_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o} !== 6'b0) begin nFail++; $display("[TB] FAIL abort_dropped: got cyc=%b resp=%b%b%b%b tmo=%b expected all 0", s_cyc_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o); end
    slaveMode = 0;
    m1_stb_i = 1'b0;
    idle(1);
    nChecks++;
    if ({s_cyc_o, grant_o, s_adr_o} !== {2'b10, 14'h40}) begin nFail++; $display("[TB] FAIL abort_next_grant: got %b%b/%h expected 10/0040", s_cyc_o, grant_o, s_adr_o); end
    idle(1);
    nChecks++;
    if ({m0_ack_o, m1_ack_o, m1_err_o, m0_dat_o} !== {3'b100, expData(14'h40)}) begin nFail++; $display("[TB] FAIL abort_m0_served: got %b%b%b/%h expected 100/%h", m0_ack_o, m1_ack_o, m1_err_o, m0_dat_o, expData(14'h40)); end
    driveReq(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    modelLast = 0;
    idle(1);
  endtask

  task automatic test_random();
    xfer_t r;
    logic [31:0] modelDat [2];
    logic known [2];
    int m, wt, mode, sel4, hits, expCycles;
    logic we, legal, expErr;
    logic [AW-1:0] adr;
    logic [3:0] sel;
    logic [31:0] wdat, expR, otherDat;
    known[0] = 1'b0; known[1] = 1'b0;
    modelDat[0] = '0; modelDat[1] = '0;
    for (int k = 0; k < 24; k++) begin
      m = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      sel4 = $urandom_range(0, 15);
      sel = 4'(sel4);
      wdat = $urandom;
      wt = $urandom_range(0, 3);
      mode = $urandom_range(0, 9);
      slaveMode = (mode < 6) ? 0 : (mode < 8) ? 1 : 3;
      slaveWait = wt;
      case ($urandom_range(0, 3))
        0: adr = 14'($urandom_range(MAP_SIZE, (1 << AW) - 1));
        1: adr = 14'($urandom_range(0, MAP_SIZE / 4 - 1) * 4 + $urandom_range(1, 3));
        default: adr = 14'($urandom_range(0, MAP_SIZE / 4 - 1) * 4);
      endcase
      legal = (int'(adr) < MAP_SIZE) && (adr % 4 == 0);
      expErr = !legal || (slaveMode != 0);
      expCycles = legal ? 2 + wt : 1;
      expR = expErr ? 32'h0 : expData(adr);
      hits = slvHits;
      runXfer(m, we, adr, sel, wdat, r);
      nChecks++;
      if ({r.ack, r.err, r.rdat} !== {!expErr, expErr, expR}) begin nFail++; $display("[TB] FAIL random_resp_%0d: got %b%b/%h expected %b%b/%h", k, r.ack, r.err, r.rdat, !expErr, expErr, expR); end
      nChecks++;
      if ({r.cycles, r.sawSlave, r.otherResp, r.tmoCount} !== {expCycles, legal, 1'b0, 32'd0}) begin nFail++; $display("[TB] FAIL random_timing_%0d: got cyc=%0d slave=%b other=%b tmo=%0d expected cyc=%0d slave=%b other=0 tmo=0", k, r.cycles, r.sawSlave, r.otherResp, r.tmoCount, expCycles, legal); end
      nChecks++;
      if (legal) begin
        if ({slvHits - hits, slvAdr, slvWe, slvSel, slvDat} !== {32'd1, adr, we, sel, wdat}) begin nFail++; $display("[TB] FAIL random_slave_req_%0d: got hits=%0d %h/%b/%h/%h expected 1 %h/%b/%h/%h", k, slvHits - hits, slvAdr, slvWe, slvSel, slvDat, adr, we, sel, wdat); end
      end else begin
        if (slvHits !== hits) begin nFail++; $display("[TB] FAIL random_slave_untouched_%0d: got %0d hits expected 0", k, slvHits - hits); end
      end
      otherDat = (m == 0) ? m1_dat_o : m0_dat_o;
      if (known[1 - m]) begin
        nChecks++;
        if (otherDat !== modelDat[1 - m]) begin nFail++; $display("[TB] FAIL random_other_held_%0d: got %h expected %h", k, otherDat, modelDat[1 - m]); end
      end
      modelDat[m] = expR;
      known[m] = 1'b1;
      modelLast = m;
      idle(1);
    end
  endtask

  task automatic test_reset_mid_busy();
    xfer_t r0, r1;
    slaveMode = 0; slaveWait = 2;
    driveReq(0, 1'b1, 1'b0, 14'h8, 4'hF, 32'h0);
    idle(3);
    rst_i = 1'b1;
    driveReq(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    idle(1);
    nChecks++;
    if (allOut !== '0) begin nFail++; $display("[TB] FAIL midreset_outputs: got %h expected 0", allOut); end
    rst_i = 1'b0;
    modelLast = 1;
    idle(1);
    nChecks++;
    if (allOut !== '0) begin nFail++; $display("[TB] FAIL midreset_no_late_ack: got %h expected 0", allOut); end
    slaveWait = 0;
    fork
      runXfer(0, 1'b0, 14'h10, 4'hF, 32'h0, r0);
      runXfer(1, 1'b0, 14'h14, 4'hF, 32'h0, r1);
    join
    nChecks++;
    if (r0.cycles !== 2 || r1.cycles !== 5) begin nFail++; $display("[TB] FAIL midreset_first_tie: got m0=%0d m1=%0d cycles expected m0=2 m1=5", r0.cycles, r1.cycles); end
    nChecks++;
    if ({r0.ack, r1.ack, r0.grant, r1.grant} !== 4'b1101) begin nFail++; $display("[TB] FAIL midreset_tie_resp: got %b%b%b%b expected 1101", r0.ack, r1.ack, r0.grant, r1.grant); end
    idle(1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    driveReq(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    driveReq(1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    test_reset();
    test_single_read();
    test_illegal();
    test_contention();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
